game_tick_ctrl: RTL and testbench
=================================

GAME_TICK_CTRL -- requirements
Module: game_tick_ctrl

Interface
REQ-001 Parameter TICK_CYCLES, default 25000000, clock cycles between successive step requests; legal range >= 6.
REQ-002 Parameter RESULT_LAT, default 2, cycles from stepReq asserted to moveResult valid.
REQ-003 Parameter INIT_LIVES, default 3, lives loaded at game start; legal range 1..3.
REQ-004 Parameter START_POS, default 2, car lane loaded at game start; legal range 0..5.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  level; begins a game from IDLE or OVER.
REQ-008 moveResult  input  2  collision-checker result: 00 none, 10 left, 01 right, 11 hit.
REQ-009 stepReq  output  1  one-cycle pulse that launches one collision-checker evaluation.
REQ-010 rowShift  output  1  one-cycle pulse commanding the obstacle-row shifter to scroll one row.
REQ-011 position  output  3  current car lane, 0..5.
REQ-012 lives  output  2  remaining lives.
REQ-013 score  output  16  completed steps in the current game.
REQ-014 gameOver  output  1  high while in OVER.

Function
REQ-015 The block SHALL implement states IDLE, RUN, REQ, WAIT, APPLY, OVER; every output SHALL be registered.
REQ-016 IDLE: start=1 -> RUN; tick counter cleared to 0; lives=INIT_LIVES, position=START_POS, score=0.
REQ-017 RUN: tick counter increments each cycle; when it reaches TICK_CYCLES-1 -> REQ.
REQ-018 REQ: stepReq=1 for exactly this cycle; tick counter cleared to 0 and keeps counting through REQ/WAIT/APPLY so stepReq pulses are exactly TICK_CYCLES cycles apart.
REQ-019 WAIT: lasts RESULT_LAT-1 cycles; moveResult SHALL be sampled at the end of the cycle RESULT_LAT cycles after the stepReq cycle -> APPLY.
REQ-020 APPLY, sampled 10: position increments unless already 5, where it holds.
REQ-021 APPLY, sampled 01: position decrements unless already 0, where it holds.
REQ-022 APPLY, sampled 00: position holds.
REQ-023 APPLY, sampled 11: position holds and lives decrements by 1.
REQ-024 In APPLY, score SHALL increment by 1, saturating at 16'hFFFF, for every sampled value except a hit that takes lives to 0.
REQ-025 rowShift SHALL pulse for one cycle, the cycle after APPLY, unless the game ended in that APPLY.
REQ-026 If lives reaches 0 in APPLY -> OVER: gameOver=1; stepReq and rowShift stay 0; position, score and lives=0 hold.
REQ-027 OVER: start=1 -> RUN with the REQ-016 initialisation and gameOver=0 in the next cycle.
REQ-028 start SHALL be ignored in RUN, REQ, WAIT and APPLY.
REQ-029 moveResult SHALL be ignored in every cycle other than the sample cycle of REQ-019.

Reset
REQ-030 reset=1 SHALL, at the next edge and from any state, force IDLE with stepReq=0, rowShift=0, position=START_POS, lives=INIT_LIVES, score=0, gameOver=0, tick counter=0.
REQ-031 reset SHALL take priority over start and over any pending sample or APPLY; an evaluation interrupted by reset SHALL NOT update position, lives, score or rowShift.

Verification (TICK_CYCLES=8, RESULT_LAT=2, INIT_LIVES=3, START_POS=2)
REQ-032 Reset, then start pulsed in cycle 0 -> first stepReq in cycle 9, then cycles 17, 25; rowShift in cycles 12, 20, 28.
REQ-033 Stimulus: moveResult=10 at the sample of the first step. Response: position 2->3, score 0->1, lives remain 3.
REQ-034 Stimulus: five consecutive 10 results, then 01 from position 0 after five 01 results. Response: position saturates at 5, then at 0; score counts every step.
REQ-035 Stimulus: three consecutive 11 results. Response: lives 3->2->1->0, gameOver=1 after the third, with no rowShift and no further stepReq. Then start -> lives=3, position=2, score=0, gameOver=0.
REQ-036 Stimulus: reset asserted in the cycle after stepReq, with moveResult=11 presented. Response: IDLE reset values, lives stays 3, no rowShift, no stepReq until start.
REQ-037 Stimulus: start held high through RUN and the step sequence. Response: tick timing unchanged and no re-initialisation of score or position.

Source files
------------

// File: rtl/game_tick_ctrl.sv
// Game step sequencer: paces collision-checker requests, applies their results
// to lane/lives/score and commands the obstacle row to scroll after each step.
module game_tick_ctrl #(
   parameter int unsigned TICK_CYCLES = 25000000,
   parameter int unsigned RESULT_LAT  = 2,
   parameter int unsigned INIT_LIVES  = 3,
   parameter int unsigned START_POS   = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  moveResult,
   output logic        stepReq,
   output logic        rowShift,
   output logic [2:0]  position,
   output logic [1:0]  lives,
   output logic [15:0] score,
   output logic        gameOver
);

   localparam int unsigned TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int unsigned WW = $clog2(RESULT_LAT + 1);
   localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_CYCLES - 1);
   localparam logic [WW-1:0] WAIT_LAST  = WW'(RESULT_LAT - 1);
   localparam logic [2:0]    POS_INIT   = 3'(START_POS);
   localparam logic [1:0]    LIVES_INIT = 2'(INIT_LIVES);

   typedef enum logic [2:0] {S_IDLE, S_RUN, S_REQ, S_WAIT, S_APPLY, S_OVER} state_e;

   state_e        state_q, state_d;
   logic [TW-1:0] tick_q, tick_d;
   logic [WW-1:0] wait_q, wait_d;
   logic [2:0]    pos_q, pos_d;
   logic [1:0]    lives_q, lives_d;
   logic [15:0]   score_q, score_d;
   logic          step_req_q, step_req_d;
   logic          row_shift_q, row_shift_d;
   logic          game_over_q, game_over_d;

   always_comb begin
      // NOTE: every signal is given a default before the case so no path can infer a latch.
      state_d     = state_q;
      tick_d      = tick_q + TW'(1);
      wait_d      = wait_q;
      pos_d       = pos_q;
      lives_d     = lives_q;
      score_d     = score_q;
      step_req_d  = 1'b0;
      row_shift_d = 1'b0;
      game_over_d = game_over_q;

      case (state_q)
         S_IDLE, S_OVER: begin
            tick_d = '0;
            if (start) begin
               state_d     = S_RUN;
               pos_d       = POS_INIT;
               lives_d     = LIVES_INIT;
               score_d     = '0;
               game_over_d = 1'b0;
            end
         end
         S_RUN: begin
            // The tick counter is restarted on entry to REQ so requests stay exactly TICK_CYCLES apart.
            if (tick_q == TICK_LAST) begin
               state_d    = S_REQ;
               tick_d     = '0;
               step_req_d = 1'b1;
            end
         end
         S_REQ: begin
            if (RESULT_LAT == 1) begin
               state_d = S_APPLY;
            end else begin
               state_d = S_WAIT;
               wait_d  = WW'(1);
            end
         end
         S_WAIT: begin
            if (wait_q == WAIT_LAST) state_d = S_APPLY;
            else                     wait_d  = wait_q + WW'(1);
         end
         S_APPLY: begin
            case (moveResult)
               2'b10:   if (pos_q != 3'd5) pos_d = pos_q + 3'd1;
               2'b01:   if (pos_q != 3'd0) pos_d = pos_q - 3'd1;
               2'b11:   lives_d = lives_q - 2'd1;
               default: ;
            endcase
            if (moveResult == 2'b11 && lives_q == 2'd1) begin
               state_d     = S_OVER;
               game_over_d = 1'b1;
               tick_d      = '0;
            end else begin
               state_d     = S_RUN;
               row_shift_d = 1'b1;
               if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
      if (reset) begin
         state_q     <= S_IDLE;
         tick_q      <= '0;
         wait_q      <= '0;
         pos_q       <= POS_INIT;
         lives_q     <= LIVES_INIT;
         score_q     <= '0;
         step_req_q  <= 1'b0;
         row_shift_q <= 1'b0;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         tick_q      <= tick_d;
         wait_q      <= wait_d;
         pos_q       <= pos_d;
         lives_q     <= lives_d;
         score_q     <= score_d;
         step_req_q  <= step_req_d;
         row_shift_q <= row_shift_d;
         game_over_q <= game_over_d;
      end
   end

   assign stepReq  = step_req_q;
   assign rowShift = row_shift_q;
   assign position = pos_q;
   assign lives    = lives_q;
   assign score    = score_q;
   assign gameOver = game_over_q;

endmodule

// File: tb/tb_game_tick_ctrl.sv
// Directed bench for game_tick_ctrl with TICK_CYCLES=8, RESULT_LAT=2, INIT_LIVES=3, START_POS=2.
module tb_game_tick_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  moveResult;
   logic        stepReq;
   logic        rowShift;
   logic [2:0]  position;
   logic [1:0]  lives;
   logic [15:0] score;
   logic        gameOver;

   int cyc       = 0;
   int pass_cnt  = 0;
   int total_cnt = 0;

   game_tick_ctrl #(
      .TICK_CYCLES(8),
      .RESULT_LAT (2),
      .INIT_LIVES (3),
      .START_POS  (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .moveResult(moveResult),
      .stepReq   (stepReq),
      .rowShift  (rowShift),
      .position  (position),
      .lives     (lives),
      .score     (score),
      .gameOver  (gameOver)
   );

   always #5 clk = ~clk;

   localparam int N_A = 15;
   logic [1:0]  a_mr    [0:N_A-1] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01,
                                      2'b01, 2'b01, 2'b01, 2'b00, 2'b11, 2'b11, 2'b11};
   logic [2:0]  a_pos   [0:N_A-1] = '{3'd3, 3'd4, 3'd5, 3'd5, 3'd5, 3'd4, 3'd3, 3'd2,
                                      3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
   logic [1:0]  a_lives [0:N_A-1] = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3,
                                      2'd3, 2'd3, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
   logic [15:0] a_score [0:N_A-1] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8,
                                      16'd9, 16'd10, 16'd11, 16'd12, 16'd13, 16'd14, 16'd14};
   logic        a_over  [0:N_A-1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      else             pass_cnt++;
   endtask

   // After the edge, #1 settles registered outputs; they then hold for the whole cycle `cyc`.
   task automatic next_cycle();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic wait_req(input string tag, input int exp_req);
      int n = 0;
      while (stepReq !== 1'b1 && n < 24) begin
         next_cycle();
         n++;
      end
      check({tag, "_req_seen"}, stepReq, 1);
      check({tag, "_req_cyc"}, cyc, exp_req);
   endtask

   // A hit value is presented outside the sample cycle; it must be ignored there.
   task automatic do_step(input string tag, input logic [1:0] mr, input int exp_req,
                          input logic [2:0] ep, input logic [1:0] el, input logic [15:0] es,
                          input logic eo);
      wait_req(tag, exp_req);
      next_cycle();
      check({tag, "_req_pulse"}, stepReq, 0);
      next_cycle();
      moveResult = mr;
      next_cycle();
      moveResult = 2'b11;
      check({tag, "_rowshift"}, rowShift, !eo);
      check({tag, "_pos"}, position, ep);
      check({tag, "_lives"}, lives, el);
      check({tag, "_score"}, score, es);
      check({tag, "_over"}, gameOver, eo);
      next_cycle();
      check({tag, "_rowshift_end"}, rowShift, 0);
   endtask

   task automatic count_quiet(input string tag, input int ncyc);
      int reqs = 0;
      int shifts = 0;
      for (int i = 0; i < ncyc; i++) begin
         next_cycle();
         if (stepReq === 1'b1)  reqs++;
         if (rowShift === 1'b1) shifts++;
      end
      check({tag, "_no_req"}, reqs, 0);
      check({tag, "_no_shift"}, shifts, 0);
   endtask

   task automatic check_init(input string tag);
      check({tag, "_pos"}, position, 3'd2);
      check({tag, "_lives"}, lives, 2'd3);
      check({tag, "_score"}, score, 16'd0);
      check({tag, "_over"}, gameOver, 0);
      check({tag, "_req"}, stepReq, 0);
      check({tag, "_shift"}, rowShift, 0);
   endtask

   initial begin
      int s;
      reset      = 1'b1;
      start      = 1'b0;
      moveResult = 2'b11;
      repeat (3) next_cycle();
      reset = 1'b0;
      check_init("reset");
      count_quiet("idle", 12);

      // Game A: lane saturation at both ends, then three hits to game over.
      s     = cyc;
      start = 1'b1;
      next_cycle();
      start = 1'b0;
      for (int k = 0; k < N_A; k++)
         do_step($sformatf("a%0d", k), a_mr[k], s + 9 + 8 * k,
                 a_pos[k], a_lives[k], a_score[k], a_over[k]);
      count_quiet("over", 24);
      check("over_hold_lives", lives, 2'd0);
      check("over_hold_over", gameOver, 1);
      check("over_hold_score", score, 16'd14);

      // Restart from OVER with start held high through several steps.
      s     = cyc;
      start = 1'b1;
      next_cycle();
      check_init("restart");
      do_step("b0", 2'b10, s + 9,  3'd3, 2'd3, 16'd1, 1'b0);
      do_step("b1", 2'b00, s + 17, 3'd3, 2'd3, 16'd2, 1'b0);
      do_step("b2", 2'b01, s + 25, 3'd2, 2'd3, 16'd3, 1'b0);
      start = 1'b0;

      // Reset in the cycle after stepReq, with a hit presented.
      wait_req("rst", s + 33);
      next_cycle();
      reset      = 1'b1;
      moveResult = 2'b11;
      next_cycle();
      reset = 1'b0;
      check_init("rst");
      count_quiet("rst_idle", 24);
      check("rst_idle_lives", lives, 2'd3);
      check("rst_idle_score", score, 16'd0);

      s     = cyc;
      start = 1'b1;
      next_cycle();
      start = 1'b0;
      do_step("c0", 2'b01, s + 9, 3'd1, 2'd3, 16'd1, 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
